order_event_sequencer: RTL and testbench
========================================

// Module: order_event_sequencer
// PURPOSE
//  Scripted stimulus engine for order_book_wrapper; successor to the fixed-case bring-up testers.
//  Holds a loadable script of DEPTH events (ADD/CANCEL/NOP/END), replays it into the book with the
//  start/busy handshake, in single-step (next pulse) or free-run mode, optionally looping.
//  Sits between the button/debounce front end (or a host loader) and order_book_wrapper.
// PARAMETERS
//  NUM_STOCKS   4     stocks addressable; stock field width = $clog2(NUM_STOCKS)
//  PRICE_W      32    price width (Q24.8 fixed point, matching book_entry)
//  ORDER_W      16    order_id width
//  QTY_W        16    quantity width
//  DEPTH        32    script entries (power of 2); AW = $clog2(DEPTH)
//  TIMEOUT      1023  max cycles to wait for book_busy_in to drop before error
// PORTS
//  clk_in          in   1        system clock
//  rst_n_in        in   1        async active-low reset
//  cfg_we_in       in   1        write script entry (ignored unless state IDLE)
//  cfg_addr_in     in   AW       script entry index
//  cfg_op_in       in   2        0 NOP, 1 ADD, 2 CANCEL, 3 END
//  cfg_stock_in    in   SW       target stock
//  cfg_price_in    in   PRICE_W  price (ADD only)
//  cfg_order_in    in   ORDER_W  order_id
//  cfg_qty_in      in   QTY_W    quantity (ADD only)
//  go_in           in   1        start replay from entry 0 (IDLE/DONE/ERROR only)
//  next_in         in   1        single-cycle advance pulse (step mode)
//  run_mode_in     in   1        1 free-run, 0 single-step; sampled on go_in
//  loop_in         in   1        1 wrap to entry 0 after END/last entry; sampled on go_in
//  abort_in        in   1        return to IDLE at next edge, from any state
//  book_busy_in    in   1        order_book_wrapper is_busy
//  book_start      out  1        one-cycle request strobe
//  book_request    out  3        ADD_ORDER / CANCEL_ORDER package codes
//  book_stock      out  SW       stock_to_add
//  book_price      out  PRICE_W  order_to_add.price
//  book_order_id   out  ORDER_W  order_to_add.order_id and order_id
//  book_quantity   out  QTY_W    order_to_add.quantity and quantity
//  book_delete     out  1        1 with CANCEL, else 0
//  busy_out        out  1        high in any state except IDLE/DONE/ERROR
//  done_out        out  1        high in DONE
//  error_out       out  1        high in ERROR (busy timeout)
//  event_idx_out   out  AW       index of current/last issued entry
//  issued_cnt_out  out  16       requests issued since go_in; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, script RAM contents undefined (not cleared).
//  Script RAM: 1 write port, synchronous read (1-cycle latency).
//  States: IDLE -go_in-> FETCH; FETCH (addr presented) -> DECODE; DECODE:
//    ADD/CANCEL -> ISSUE; NOP -> ADVANCE; END -> DONE or FETCH@0 if loop.
//  ISSUE: book_start=1 for exactly one cycle, book_* fields valid same cycle and held until next ISSUE.
//  SETTLE: one guard cycle after ISSUE (book_busy_in lags start by 1); busy not sampled.
//  WAIT_BUSY: leave when book_busy_in==0 -> ADVANCE; timeout counter starts at SETTLE exit,
//    reaching TIMEOUT with busy still high -> ERROR (book_start never reasserted).
//  ADVANCE: step mode -> WAIT_NEXT (NOP entries also wait for next_in); run mode -> idx+1, FETCH.
//  WAIT_NEXT: next_in && !book_busy_in -> idx+1, FETCH; next_in while busy is dropped (not queued).
//  Index wrap: idx==DEPTH-1 without END -> DONE, or idx=0 if loop.
//  Minimum run-mode spacing: 5 cycles between book_start pulses (FETCH, DECODE, ISSUE, SETTLE, WAIT).
//  go_in while busy_out ignored; abort_in wins over go_in/next_in same cycle; abort mid-ISSUE
//    still completes that start pulse (already driven) but no further pulse.
//  Async reset mid-operation: immediate IDLE, book_start=0 asynchronously.
//  issued_cnt_out increments on each book_start cycle; cleared on go_in.
//  run_mode_in/loop_in changes after go_in have no effect until the next go_in.
// TESTING
//  Load [ADD s0 p=2 id2 q2, ADD s0 p=4 id3, CANCEL id3, END], step mode, 4 next pulses ->
//    3 starts with matching fields, done_out=1, issued_cnt=3.
//  Same script run mode, busy held 3 cycles per request -> starts spaced 8 cycles, done_out, no error.
//  book_busy_in stuck 1 after first start, TIMEOUT=15 -> error_out=1 16 cycles after SETTLE, one start only.
//  loop_in=1, script [ADD, END], run 20 starts -> issued_cnt=20, event_idx alternates 0, never done.
//  next_in pulsed while busy, then after -> first pulse ignored, second advances exactly one entry.
//  abort_in during WAIT_BUSY, then rst_n_in low mid-FETCH -> IDLE, all outputs 0, go_in restarts at 0.

Source files
------------

// File: rtl/order_event_sequencer.sv
// Scripted stimulus engine for order_book_wrapper: replays a loadable event script through the
// book's start/busy handshake, in single-step or free-run mode, with optional looping.
module order_event_sequencer #(
  parameter int unsigned NUM_STOCKS = 4,
  parameter int unsigned PRICE_W    = 32,
  parameter int unsigned ORDER_W    = 16,
  parameter int unsigned QTY_W      = 16,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned TIMEOUT    = 1023,
  localparam int unsigned SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               cfg_we_in,
  input  logic [AW-1:0]      cfg_addr_in,
  input  logic [1:0]         cfg_op_in,
  input  logic [SW-1:0]      cfg_stock_in,
  input  logic [PRICE_W-1:0] cfg_price_in,
  input  logic [ORDER_W-1:0] cfg_order_in,
  input  logic [QTY_W-1:0]   cfg_qty_in,
  input  logic               go_in,
  input  logic               next_in,
  input  logic               run_mode_in,
  input  logic               loop_in,
  input  logic               abort_in,
  input  logic               book_busy_in,
  output logic               book_start,
  output logic [2:0]         book_request,
  output logic [SW-1:0]      book_stock,
  output logic [PRICE_W-1:0] book_price,
  output logic [ORDER_W-1:0] book_order_id,
  output logic [QTY_W-1:0]   book_quantity,
  output logic               book_delete,
  output logic               busy_out,
  output logic               done_out,
  output logic               error_out,
  output logic [AW-1:0]      event_idx_out,
  output logic [15:0]        issued_cnt_out
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] OpNop    = 2'd0;
  localparam logic [1:0] OpAdd    = 2'd1;
  localparam logic [1:0] OpCancel = 2'd2;
  localparam logic [1:0] OpEnd    = 2'd3;

  localparam logic [2:0] ReqAdd    = 3'd1;
  localparam logic [2:0] ReqCancel = 3'd2;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StIssue, StSettle,
    StWaitBusy, StAdvance, StWaitNext, StDone, StError
  } state_e;

  typedef struct packed {
    logic [1:0]         op;
    logic [SW-1:0]      stock;
    logic [PRICE_W-1:0] price;
    logic [ORDER_W-1:0] order_id;
    logic [QTY_W-1:0]   qty;
  } entry_t;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            run_q, run_d;
  logic            loop_q, loop_d;
  logic [15:0]     issued_q, issued_d;
  logic            do_step;
  logic            go_ok;

  entry_t          script_mem [DEPTH];
  entry_t          rd_q;
  entry_t          wr_entry;

  logic [2:0]         req_q;
  logic [SW-1:0]      stock_q;
  logic [PRICE_W-1:0] price_q;
  logic [ORDER_W-1:0] order_q;
  logic [QTY_W-1:0]   qty_q;
  logic               del_q;

  assign wr_entry = '{op: cfg_op_in, stock: cfg_stock_in, price: cfg_price_in,
                      order_id: cfg_order_in, qty: cfg_qty_in};

  // Script RAM: no reset, read registered so data for FETCH's address is valid in DECODE.
  always_ff @(posedge clk_in) begin
    if (cfg_we_in && (state_q == StIdle)) begin
      script_mem[cfg_addr_in] <= wr_entry;
    end
    rd_q <= script_mem[idx_q];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    run_d   = run_q;
    loop_d  = loop_q;
    do_step = 1'b0;
    go_ok   = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (go_in) begin
          go_ok   = 1'b1;
          state_d = StFetch;
          idx_d   = '0;
          run_d   = run_mode_in;
          loop_d  = loop_in;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (rd_q.op)
          OpAdd, OpCancel: state_d = StIssue;
          OpNop:           state_d = StAdvance;
          OpEnd: begin
            if (loop_q) begin
              idx_d   = '0;
              state_d = StFetch;
            end else begin
              state_d = StDone;
            end
          end
        endcase
      end
      StIssue: state_d = StSettle;
      StSettle: begin
        tmo_d   = '0;
        state_d = StWaitBusy;
      end
      // Advance decision folded in here so run mode keeps a 5-cycle start spacing.
      StWaitBusy: begin
        if (!book_busy_in) begin
          if (run_q) begin
            do_step = 1'b1;
          end else begin
            state_d = StWaitNext;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = StError;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StAdvance: begin
        if (run_q) begin
          do_step = 1'b1;
        end else begin
          state_d = StWaitNext;
        end
      end
      StWaitNext: begin
        if (next_in && !book_busy_in) begin
          do_step = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_step) begin
      if (idx_q == AW'(DEPTH - 1)) begin
        if (loop_q) begin
          idx_d   = '0;
          state_d = StFetch;
        end else begin
          state_d = StDone;
        end
      end else begin
        idx_d   = idx_q + AW'(1);
        state_d = StFetch;
      end
    end

    if (abort_in) begin
      state_d = StIdle;
      go_ok   = 1'b0;
    end
  end

  always_comb begin
    issued_d = issued_q;
    if (go_ok) begin
      issued_d = '0;
    end else if ((state_q == StIssue) && (issued_q != 16'hFFFF)) begin
      issued_d = issued_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      tmo_q    <= '0;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      issued_q <= '0;
      req_q    <= '0;
      stock_q  <= '0;
      price_q  <= '0;
      order_q  <= '0;
      qty_q    <= '0;
      del_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      run_q    <= run_d;
      loop_q   <= loop_d;
      issued_q <= issued_d;
      // Request fields change only on entry to ISSUE and hold until the next one.
      if (state_d == StIssue) begin
        req_q   <= (rd_q.op == OpCancel) ? ReqCancel : ReqAdd;
        stock_q <= rd_q.stock;
        price_q <= rd_q.price;
        order_q <= rd_q.order_id;
        qty_q   <= rd_q.qty;
        del_q   <= (rd_q.op == OpCancel);
      end
    end
  end

  assign book_start     = (state_q == StIssue);
  assign book_request   = req_q;
  assign book_stock     = stock_q;
  assign book_price     = price_q;
  assign book_order_id  = order_q;
  assign book_quantity  = qty_q;
  assign book_delete    = del_q;
  assign busy_out       = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
  assign done_out       = (state_q == StDone);
  assign error_out      = (state_q == StError);
  assign event_idx_out  = idx_q;
  assign issued_cnt_out = issued_q;

endmodule

// File: tb/tb_order_event_sequencer.sv
// Scoreboard bench for order_event_sequencer: a script-walking model queues expected requests,
// a monitor pops and compares on every book_start.
module tb_order_event_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;
  localparam logic [1:0] OP_NOP = 2'd0, OP_ADD = 2'd1, OP_CANCEL = 2'd2, OP_END = 2'd3;
  localparam logic [2:0] REQ_ADD = 3'd1, REQ_CANCEL = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [1:0]  cfg_op = '0;
  logic [1:0]  cfg_stock = '0;
  logic [31:0] cfg_price = '0;
  logic [15:0] cfg_order = '0;
  logic [15:0] cfg_qty = '0;
  logic        go = 1'b0, next = 1'b0, run_mode = 1'b0, loop_en = 1'b0, abort = 1'b0;
  logic        book_busy;
  logic        book_start;
  logic [2:0]  book_request;
  logic [1:0]  book_stock;
  logic [31:0] book_price;
  logic [15:0] book_order_id, book_quantity;
  logic        book_delete, busy_out, done_out, error_out;
  logic [2:0]  event_idx;
  logic [15:0] issued_cnt;

  order_event_sequencer #(
    .NUM_STOCKS(4), .PRICE_W(32), .ORDER_W(16), .QTY_W(16), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .cfg_we_in(cfg_we), .cfg_addr_in(cfg_addr),
    .cfg_op_in(cfg_op), .cfg_stock_in(cfg_stock), .cfg_price_in(cfg_price),
    .cfg_order_in(cfg_order), .cfg_qty_in(cfg_qty), .go_in(go), .next_in(next),
    .run_mode_in(run_mode), .loop_in(loop_en), .abort_in(abort), .book_busy_in(book_busy),
    .book_start(book_start), .book_request(book_request), .book_stock(book_stock),
    .book_price(book_price), .book_order_id(book_order_id), .book_quantity(book_quantity),
    .book_delete(book_delete), .busy_out(busy_out), .done_out(done_out),
    .error_out(error_out), .event_idx_out(event_idx), .issued_cnt_out(issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [1:0]  stock;
    logic [31:0] price;
    logic [15:0] oid;
    logic [15:0] qty;
    logic        del;
    logic [2:0]  idx;
    int unsigned ord;
  } exp_t;

  exp_t exp_q[$];
  exp_t plan_q[$];
  exp_t mon_e;
  int   start_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   seen_done = 1'b0;

  logic [1:0]  op_m[DEPTH];
  logic [1:0]  stock_m[DEPTH];
  logic [31:0] price_m[DEPTH];
  logic [15:0] oid_m[DEPTH];
  logic [15:0] qty_m[DEPTH];

  // Book emulator: busy rises the cycle after a start and stays up busy_len cycles.
  int busy_cnt = 0;
  int busy_len = 1;
  bit busy_force = 1'b0;
  bit busy_stuck = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (book_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign book_busy = (busy_cnt > 0) || busy_force || busy_stuck;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every start must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && book_start) begin
      start_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start actual=idx%0d required=no_start", event_idx);
      end else begin
        mon_e = exp_q.pop_front();
        chk("start_request", 64'(book_request), 64'(mon_e.req));
        chk("start_stock", 64'(book_stock), 64'(mon_e.stock));
        chk("start_order_id", 64'(book_order_id), 64'(mon_e.oid));
        chk("start_quantity", 64'(book_quantity), 64'(mon_e.qty));
        chk("start_delete", 64'(book_delete), 64'(mon_e.del));
        chk("start_event_idx", 64'(event_idx), 64'(mon_e.idx));
        chk("start_issued_cnt", 64'(issued_cnt), 64'(mon_e.ord));
        if (!mon_e.del) chk("start_price", 64'(book_price), 64'(mon_e.price));
      end
    end
    if (done_out) seen_done = 1'b1;
  end

  // Walk the script per its rules and queue the requests it should produce.
  task automatic plan(input bit lp, input int maxn);
    int   idx = 0;
    int   n = 0;
    exp_t e;
    plan_q.delete();
    for (int g = 0; g < 4096 && n < maxn; g++) begin
      if (op_m[idx] == OP_END) begin
        if (lp) begin
          idx = 0;
          continue;
        end
        break;
      end
      if (op_m[idx] == OP_ADD || op_m[idx] == OP_CANCEL) begin
        e.req   = (op_m[idx] == OP_ADD) ? REQ_ADD : REQ_CANCEL;
        e.stock = stock_m[idx];
        e.price = price_m[idx];
        e.oid   = oid_m[idx];
        e.qty   = qty_m[idx];
        e.del   = (op_m[idx] == OP_CANCEL);
        e.idx   = 3'(idx);
        e.ord   = n;
        plan_q.push_back(e);
        n++;
      end
      if (idx == DEPTH - 1) begin
        if (lp) idx = 0;
        else break;
      end else begin
        idx++;
      end
    end
  endtask

  task automatic arm(input int k);
    for (int i = 0; i < k && plan_q.size() > 0; i++) exp_q.push_back(plan_q.pop_front());
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int a, input logic [1:0] op, input logic [1:0] st,
                      input logic [31:0] pr, input logic [15:0] id, input logic [15:0] q);
    op_m[a] = op; stock_m[a] = st; price_m[a] = pr; oid_m[a] = id; qty_m[a] = q;
    cfg_addr = 3'(a); cfg_op = op; cfg_stock = st; cfg_price = pr; cfg_order = id; cfg_qty = q;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_drained(input string nm, input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Wait for DONE/ERROR; in step mode keep offering next pulses.
  task automatic wait_done(input string nm, input bit step, input int bound);
    int k = 0;
    while (!done_out && !error_out && k < bound) begin
      next = step && (k % 10 == 5);
      @(negedge clk);
      k++;
    end
    next = 1'b0;
    chk(nm, 64'(done_out), 64'd1);
  endtask

  task automatic load_script_a();
    load(0, OP_ADD, 2'd0, 32'd2, 16'd2, 16'd2);
    load(1, OP_ADD, 2'd0, 32'd4, 16'd3, 16'd5);
    load(2, OP_CANCEL, 2'd0, 32'd0, 16'd3, 16'd0);
    load(3, OP_END, 2'd0, 32'd0, 16'd0, 16'd0);
  endtask

  task automatic load_three_adds();
    for (int i = 0; i < 3; i++)
      load(i, OP_ADD, 2'($urandom_range(0, 3)), $urandom, 16'($urandom), 16'($urandom));
    load(3, OP_END, 2'd0, 32'd0, 16'd0, 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int k;
    cycles(3);
    chk("reset_status", 64'({book_start, busy_out, done_out, error_out, event_idx, issued_cnt}),
        64'd0);
    chk("reset_fields", 64'({book_request, book_stock, book_delete, book_order_id,
                             book_quantity}), 64'd0);
    chk("reset_price", 64'(book_price), 64'd0);
    rst_n = 1'b1;
    cycles(2);

    // Step mode, four next pulses: three starts then DONE.
    load_script_a();
    busy_len = 2; run_mode = 1'b0; loop_en = 1'b0;
    plan(1'b0, 1000); arm(plan_q.size());
    pulse_go();
    chk("step_busy_out", 64'(busy_out), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cycles(15);
      pulse_next();
    end
    wait_done("step_done", 1'b0, 30);
    chk("step_issued", 64'(issued_cnt), 64'd3);
    chk("step_no_error", 64'(error_out), 64'd0);
    chk("step_drained", 64'(exp_q.size()), 64'd0);

    // Free-run, busy held 3 cycles past the guard cycle: starts 8 apart.
    pulse_abort();
    busy_len = 4; run_mode = 1'b1;
    plan(1'b0, 1000); arm(plan_q.size());
    start_cyc.delete();
    pulse_go();
    run_mode = 1'b0;
    wait_done("run_done", 1'b0, 100);
    chk("run_no_error", 64'(error_out), 64'd0);
    chk("run_start_count", 64'(start_cyc.size()), 64'd3);
    if (start_cyc.size() >= 3) begin
      chk("run_gap_0_1", 64'(start_cyc[1] - start_cyc[0]), 64'd8);
      chk("run_gap_1_2", 64'(start_cyc[2] - start_cyc[1]), 64'd8);
    end

    // Busy stuck high: error TIMEOUT+1 cycles after SETTLE, single start.
    pulse_abort();
    busy_stuck = 1'b1; busy_len = 0; run_mode = 1'b1;
    plan(1'b0, 1); arm(1);
    start_cyc.delete();
    pulse_go();
    wait_drained("timeout_first_start", 30);
    k = 0;
    while (!error_out && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_error", 64'(error_out), 64'd1);
    if (start_cyc.size() > 0)
      chk("timeout_latency", 64'(cyc - start_cyc[0]), 64'(TIMEOUT + 2));
    cycles(5);
    chk("timeout_issued", 64'(issued_cnt), 64'd1);
    chk("timeout_busy_out", 64'(busy_out), 64'd0);
    busy_stuck = 1'b0;

    // Looping [ADD, END]: 20 starts at entry 0, never DONE.
    pulse_abort();
    load(0, OP_ADD, 2'd1, 32'h0000_0a80, 16'd7, 16'd9);
    load(1, OP_END, 2'd0, 32'd0, 16'd0, 16'd0);
    busy_len = 1; run_mode = 1'b1; loop_en = 1'b1;
    plan(1'b1, 20); arm(plan_q.size());
    seen_done = 1'b0;
    pulse_go();
    loop_en = 1'b0;
    wait_drained("loop_20_starts", 400);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cycles(12);
    chk("loop_issued", 64'(issued_cnt), 64'd20);
    chk("loop_never_done", 64'(seen_done), 64'd0);

    // next_in while busy is dropped; the following one advances exactly one entry.
    load_three_adds();
    busy_len = 1; run_mode = 1'b0;
    plan(1'b0, 1000); arm(1);
    pulse_go();
    cycles(12);
    busy_force = 1'b1;
    pulse_next();
    cycles(10);
    chk("next_busy_idx", 64'(event_idx), 64'd0);
    chk("next_busy_issued", 64'(issued_cnt), 64'd1);
    busy_force = 1'b0;
    cycles(1);
    arm(1);
    pulse_next();
    cycles(12);
    chk("next_idx", 64'(event_idx), 64'd1);
    chk("next_issued", 64'(issued_cnt), 64'd2);
    chk("next_drained", 64'(exp_q.size()), 64'd0);

    // Abort in WAIT_BUSY, then async reset mid-FETCH, then clean restart.
    pulse_abort();
    busy_len = 8; run_mode = 1'b1;
    plan(1'b0, 1000); arm(1);
    pulse_go();
    wait_drained("abort_first_start", 20);
    cycles(3);
    pulse_abort();
    chk("abort_busy_out", 64'(busy_out), 64'd0);
    cycles(15);
    chk("abort_issued", 64'(issued_cnt), 64'd1);
    pulse_go();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_status", 64'({book_start, busy_out, done_out, error_out, event_idx,
                              issued_cnt}), 64'd0);
    chk("areset_fields", 64'({book_request, book_stock, book_delete, book_order_id,
                              book_quantity}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    load_three_adds();
    busy_len = 2;
    plan(1'b0, 1000); arm(plan_q.size());
    pulse_go();
    wait_done("restart_done", 1'b0, 100);
    chk("restart_issued", 64'(issued_cnt), 64'd3);

    // Randomized scripts in both modes.
    for (int it = 0; it < 8; it++) begin
      int r;
      bit stp;
      pulse_abort();
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 9);
        load(i, (r < 2) ? OP_NOP : (r < 6) ? OP_ADD : (r < 9) ? OP_CANCEL : OP_END,
             2'($urandom_range(0, 3)), $urandom, 16'($urandom), 16'($urandom));
      end
      stp = 1'($urandom_range(0, 1));
      busy_len = $urandom_range(0, 4);
      run_mode = !stp; loop_en = 1'b0;
      plan(1'b0, 1000);
      s0 = plan_q.size();
      arm(s0);
      pulse_go();
      wait_done("rand_done", stp, 1500);
      chk("rand_issued", 64'(issued_cnt), 64'(s0));
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
